led_sequencer: RTL and testbench

Timed LED playback engine that sits downstream of the game `controller`. It takes one colour code at a time from the memory read path and lights the matching LED for a speed-dependent on-time, followed by a blank gap. It also performs the all-LED flash used for win/fail indication. The controller steps through the stored sequence using a valid/ready/done handshake, so it never counts display time itself.

---
 rtl/led_sequencer_if.sv | 39 +++
 rtl/led_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_led_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_sequencer_if.sv
// Handshake and LED drive bundle between the game controller and led_sequencer.
// The tone line exists only when LED_SEQUENCER_TONE_EN is defined.
interface led_sequencer_if #(
   parameter int unsigned COLOR_CODEFY_W = 2
);
   logic                      show_valid;
   logic [COLOR_CODEFY_W-1:0] color;
   logic                      speed;
   logic                      flash_req;
   logic                      show_ready;
   logic                      done;
   logic                      led_green;
   logic                      led_red;
   logic                      led_blue;
   logic                      led_yellow;
`ifdef LED_SEQUENCER_TONE_EN
   logic                      tone;

   modport master (
      output show_valid, color, speed, flash_req,
      input  show_ready, done, led_green, led_red, led_blue, led_yellow, tone
   );

   modport slave (
      input  show_valid, color, speed, flash_req,
      output show_ready, done, led_green, led_red, led_blue, led_yellow, tone
   );
`else
   modport master (
      output show_valid, color, speed, flash_req,
      input  show_ready, done, led_green, led_red, led_blue, led_yellow
   );

   modport slave (
      input  show_valid, color, speed, flash_req,
      output show_ready, done, led_green, led_red, led_blue, led_yellow
   );
`endif
endinterface

// File: rtl/led_sequencer.sv
// Timed LED playback engine: one colour per show (on-time then gap) and an all-LED flash.
// Define LED_SEQUENCER_TONE_EN to add the tone output and its divider.
module led_sequencer #(
   parameter int unsigned COLOR_CODEFY_W = 2,
   parameter int unsigned ON_SLOW        = 25_000_000,
   parameter int unsigned ON_FAST        = 12_500_000,
   parameter int unsigned GAP            = 5_000_000,
   parameter int unsigned FLASH_COUNT    = 3
`ifdef LED_SEQUENCER_TONE_EN
   ,
   parameter int unsigned TONE_DIV       = 25_000
`endif
) (
   input logic            clk,
   input logic            rst,
   led_sequencer_if.slave bus
);

   localparam int unsigned ON_MAX = (ON_SLOW > ON_FAST) ? ON_SLOW : ON_FAST;
   localparam int unsigned T_MAX  = (ON_MAX > GAP) ? ON_MAX : GAP;
   localparam int unsigned TMR_W  = $clog2(T_MAX + 1);
   localparam int unsigned FC_W   = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;
   localparam int unsigned LED_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ON,
      ST_GAP,
      ST_FL_ON,
      ST_FL_GAP
   } state_t;

   state_t                    state_q, state_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic [FC_W-1:0]           flash_cnt_q, flash_cnt_d;
   logic [COLOR_CODEFY_W-1:0] color_q, color_d;
   logic [LED_W-1:0]          led_q, led_d;
   logic                      done_q, done_d;
   logic                      ready_q, ready_d;
   logic                      timer_zero;

   assign timer_zero = (timer_q == '0);

   // State and output registers; outputs are computed from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         flash_cnt_q <= '0;
         color_q     <= '0;
         led_q       <= '0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         flash_cnt_q <= flash_cnt_d;
         color_q     <= color_d;
         led_q       <= led_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      flash_cnt_d = flash_cnt_q;
      color_d     = color_q;
      done_d      = 1'b0;
      led_d       = '0;

      unique case (state_q)
         ST_IDLE: begin
            // Flash has priority; a simultaneous show request is dropped.
            if (bus.flash_req) begin
               state_d     = ST_FL_ON;
               flash_cnt_d = FC_W'(FLASH_COUNT - 1);
               timer_d     = TMR_W'(ON_SLOW - 1);
            end else if (bus.show_valid) begin
               state_d = ST_ON;
               color_d = bus.color;
               timer_d = bus.speed ? TMR_W'(ON_FAST - 1) : TMR_W'(ON_SLOW - 1);
            end
         end
         ST_ON: begin
            if (timer_zero) begin
               state_d = ST_GAP;
               timer_d = TMR_W'(GAP - 1);
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (timer_zero) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_FL_ON: begin
            if (timer_zero) begin
               state_d = ST_FL_GAP;
               timer_d = TMR_W'(GAP - 1);
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_FL_GAP: begin
            if (timer_zero) begin
               if (flash_cnt_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_FL_ON;
                  flash_cnt_d = flash_cnt_q - FC_W'(1);
                  timer_d     = TMR_W'(ON_SLOW - 1);
               end
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // LED drive for the cycle that state_d will occupy.
      unique case (state_d)
         ST_ON: begin
            led_d[0] = (color_d == COLOR_CODEFY_W'(0));
            led_d[1] = (color_d == COLOR_CODEFY_W'(1));
            led_d[2] = (color_d == COLOR_CODEFY_W'(2));
            led_d[3] = (color_d == COLOR_CODEFY_W'(3));
         end
         ST_FL_ON: led_d = '1;
         default:  led_d = '0;
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   assign bus.led_green  = led_q[0];
   assign bus.led_red    = led_q[1];
   assign bus.led_blue   = led_q[2];
   assign bus.led_yellow = led_q[3];
   assign bus.done       = done_q;
   assign bus.show_ready = ready_q;

`ifdef LED_SEQUENCER_TONE_EN
   localparam int unsigned TONE_MAX = TONE_DIV * (2 ** COLOR_CODEFY_W);
   localparam int unsigned TONE_W   = $clog2(TONE_MAX + 1);

   logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
   logic [TONE_W-1:0] tone_period;
   logic              tone_q, tone_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else begin
         tone_cnt_q <= tone_cnt_d;
         tone_q     <= tone_d;
      end
   end

   // Half-period counter; restarts low on every entry into ON or FL_ON.
   always_comb begin
      tone_d      = 1'b0;
      tone_cnt_d  = '0;
      tone_period = TONE_W'(TONE_DIV);
      if (state_d == ST_ON) begin
         tone_period = TONE_W'(TONE_DIV) * (TONE_W'(color_d) + TONE_W'(1));
      end
      if ((state_d == ST_ON) || (state_d == ST_FL_ON)) begin
         if (state_d != state_q) begin
            tone_cnt_d = tone_period - TONE_W'(1);
         end else if (tone_cnt_q == '0) begin
            tone_d     = ~tone_q;
            tone_cnt_d = tone_period - TONE_W'(1);
         end else begin
            tone_d     = tone_q;
            tone_cnt_d = tone_cnt_q - TONE_W'(1);
         end
      end
   end

   assign bus.tone = tone_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed vector table, hand sequences, and random
// stimulus against a schedule-based reference model (tone checked when LED_SEQUENCER_TONE_EN is set).
module tb_led_sequencer;

   localparam int ON_SLOW = 8;
   localparam int ON_FAST = 4;
   localparam int GAP     = 2;
   localparam int FC      = 2;
   localparam int TDIV    = 1;
   localparam int PER     = ON_SLOW + GAP;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   led_sequencer_if #(.COLOR_CODEFY_W(2)) bus ();

   led_sequencer #(
      .COLOR_CODEFY_W(2),
      .ON_SLOW       (ON_SLOW),
      .ON_FAST       (ON_FAST),
      .GAP           (GAP),
      .FLASH_COUNT   (FC)
`ifdef LED_SEQUENCER_TONE_EN
      ,
      .TONE_DIV      (TDIV)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // {sv, color, speed, flash, rst} inputs and {yellow,blue,red,green,done,ready} expectation
   typedef struct packed {
      logic       sv;
      logic [1:0] col;
      logic       spd;
      logic       fr;
      logic       r;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl[$];

   int n_vec = 0;
   int n_bad = 0;
   int done_seen = 0;

   // Reference model: a request accepted at edge 'start' defines the whole timeline arithmetically.
   int         cyc     = 0;
   int         m_start = 0;
   int         m_end   = 0;
   int         m_t     = 0;
   bit         m_busy  = 1'b0;
   bit         m_flash = 1'b0;
   logic [1:0] m_col   = 2'd0;

   function automatic vec_t mk(input logic sv, input logic [1:0] col, input logic spd,
                               input logic fr, input logic r, input logic [5:0] exp);
      vec_t v;
      v.sv = sv; v.col = col; v.spd = spd; v.fr = fr; v.r = r; v.exp = exp;
      return v;
   endfunction

   function automatic logic [5:0] model_out();
      int         k;
      logic [3:0] l;
      logic       d;
      logic       rd;
      l  = 4'b0000;
      d  = 1'b0;
      rd = 1'b1;
      if (m_busy) begin
         k  = cyc - m_start;
         rd = (k == m_end);
         d  = rd;
         if (m_flash) begin
            if ((k <= FC * PER) && (((k - 1) % PER) < ON_SLOW)) l = 4'b1111;
         end else if (k <= m_t) begin
            l = 4'b0001 << m_col;
         end
      end
      return {l, d, rd};
   endfunction

   function automatic logic model_tone();
      int k;
      int j;
      if (!m_busy) return 1'b0;
      k = cyc - m_start;
      if (m_flash) begin
         if (k > FC * PER) return 1'b0;
         j = (k - 1) % PER;
         if (j >= ON_SLOW) return 1'b0;
         return ((j / TDIV) % 2) == 1;
      end
      if (k > m_t) return 1'b0;
      return (((k - 1) / (TDIV * (int'(m_col) + 1))) % 2) == 1;
   endfunction

   task automatic model_edge(input logic sv, input logic [1:0] col, input logic spd,
                             input logic fr, input logic r);
      int k;
      bit rdy;
      k   = cyc - m_start;
      rdy = !m_busy || (k == m_end);
      if (m_busy && (k == m_end)) m_busy = 1'b0;
      cyc++;
      if (r) begin
         m_busy = 1'b0;
      end else if (rdy && fr) begin
         m_busy  = 1'b1;
         m_flash = 1'b1;
         m_start = cyc - 1;
         m_end   = FC * PER + 1;
      end else if (rdy && sv) begin
         m_busy  = 1'b1;
         m_flash = 1'b0;
         m_start = cyc - 1;
         m_col   = col;
         m_t     = spd ? ON_FAST : ON_SLOW;
         m_end   = m_t + GAP + 1;
      end
   endtask

   // Drive inputs for one cycle, clock, then compare against the table value or the model.
   task automatic step(input logic sv, input logic [1:0] col, input logic spd, input logic fr,
                       input logic r, input bit use_tbl, input logic [5:0] tbl_exp,
                       input string name);
      logic [5:0] got;
      logic [5:0] exp;
      bus.show_valid = sv;
      bus.color      = col;
      bus.speed      = spd;
      bus.flash_req  = fr;
      rst            = r;
      @(posedge clk);
      model_edge(sv, col, spd, fr, r);
      #1;
      exp = use_tbl ? tbl_exp : model_out();
      got = {bus.led_yellow, bus.led_blue, bus.led_red, bus.led_green, bus.done, bus.show_ready};
      if (got === 6'b000010 || got === 6'b000011 || got[1] === 1'b1) done_seen += int'(got[1]);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got {ylw,blu,red,grn,done,rdy}=%b required %b",
                  name, cyc, got, exp);
      end
`ifdef LED_SEQUENCER_TONE_EN
      n_vec++;
      if (bus.tone !== model_tone()) begin
         n_bad++;
         $display("FAIL %s_tone cycle %0d: got %b required %b", name, cyc, bus.tone, model_tone());
      end
`endif
   endtask

   task automatic idle(input int n, input string name);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0, name);
   endtask

   task automatic check_done_count(input int required, input string name);
      n_vec++;
      if (done_seen != required) begin
         n_bad++;
         $display("FAIL %s: got %0d done pulses required %0d", name, done_seen, required);
      end
   endtask

   initial begin
      bus.show_valid = 1'b0;
      bus.color      = 2'd0;
      bus.speed      = 1'b0;
      bus.flash_req  = 1'b0;

      // Reset held three cycles, then slow blue, then fast yellow with an ignored busy request.
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 6'b000001));
      tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000001));
      tbl.push_back(mk(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 6'b010000));
      for (int i = 2; i <= 8; i++) tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b010000));
      for (int i = 9; i <= 10; i++) tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000000));
      tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000011));
      tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000001));
      tbl.push_back(mk(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 6'b100000));
      tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b100000));
      tbl.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 6'b100000));
      tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b100000));
      for (int i = 5; i <= 6; i++) tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000000));
      tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000011));
      tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'b000001));

      foreach (tbl[i]) begin
         step(tbl[i].sv, tbl[i].col, tbl[i].spd, tbl[i].fr, tbl[i].r, 1'b1, tbl[i].exp,
              $sformatf("table[%0d]", i));
      end

      // Simultaneous show and flash: flash wins, exactly one done at cycle 21.
      done_seen = 0;
      step(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0, "simul");
      idle(22, "simul");
      check_done_count(1, "simul_done_count");

      // Red slow show interrupted by reset in cycle 5, then a slow blue show right after release.
      done_seen = 0;
      step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0, "midrst");
      idle(4, "midrst");
      step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b0, "midrst_rst");
      idle(1, "midrst_idle");
      check_done_count(0, "midrst_no_done");
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0, "after_rst");
      idle(12, "after_rst");
      check_done_count(1, "after_rst_done_count");

      // Back-to-back fast shows: each new request presented in the done cycle.
      step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b0, "b2b");
      for (int n = 0; n < 3; n++) begin
         idle(ON_FAST + GAP, "b2b");
         step(1'b1, 2'(n + 1), 1'b1, 1'b0, 1'b0, 1'b0, 6'b0, "b2b");
      end
      idle(ON_FAST + GAP + 2, "b2b");

      // Random traffic, including requests while busy and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0), 1'b0, 6'b0, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
